// File: rtl/sr_ctrl_multi_if.sv
// Pixel-engine side of the LED-wall serialiser: data word handshake.
// SR_CHAN_MASK_EN adds the per-strip chan_mask lane.
interface sr_ctrl_multi_if #(
  parameter int unsigned CHANNELS = 8
);
  logic [CHANNELS-1:0] data_in;
  logic                data_valid;
  logic                frame_end;
  logic                data_ready;
`ifdef SR_CHAN_MASK_EN
  logic [CHANNELS-1:0] chan_mask;

  modport master (output data_in, data_valid, frame_end, chan_mask, input data_ready);
  modport slave  (input data_in, data_valid, frame_end, chan_mask, output data_ready);
`else
  modport master (output data_in, data_valid, frame_end, input data_ready);
  modport slave  (input data_in, data_valid, frame_end, output data_ready);
`endif
endinterface

// File: rtl/sr_ctrl_multi.sv
// WS2812 parallel-strip 74HC595 serialiser: each word -> ONE/DATA/ZERO SR words, plus LED reset.
// Optional per-strip masking of ONE/DATA words when SR_CHAN_MASK_EN is defined.
module sr_ctrl_multi #(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned RESET_SLOTS = 200
) (
  input  logic           sr_clk,
  input  logic           ar,
  sr_ctrl_multi_if.slave bus,
  input  logic           led_reset_req,
  output logic           ser_out,
  output logic           sr_latch,
  output logic           busy
);
  localparam int unsigned   BW       = $clog2(CHANNELS);
  localparam int unsigned   RST_LEN  = RESET_SLOTS * CHANNELS;
  localparam int unsigned   RW       = $clog2(RST_LEN + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CHANNELS - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_LEN - 1);

  typedef enum logic [2:0] {IDLE, ONE, DATA, ZERO, RST} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [CHANNELS-1:0] hold_q, hold_d;
  logic [CHANNELS-1:0] mask_d;
  logic                fe_q, fe_d;
  logic                pend_q, pend_d;
  logic                ser_q, ser_d;
  logic                latch_q, latch_d;
  logic                word_end, rst_last, ready, accept;

  assign word_end = (state_q != IDLE) && (bit_cnt_q == BIT_LAST);
  assign rst_last = (state_q == RST) && (rst_cnt_q == RST_LAST);
  // ar gates ready so the handshake is closed for the whole reset window
  assign ready    = ~ar & ~pend_q & ~led_reset_req &
                    ((state_q == IDLE) | ((state_q == ZERO) && word_end && !fe_q) | rst_last);
  assign accept   = bus.data_valid & ready;

  assign bus.data_ready = ready;
  assign ser_out        = ser_q;
  assign sr_latch       = latch_q;
  assign busy           = (state_q != IDLE);

`ifdef SR_CHAN_MASK_EN
  logic [CHANNELS-1:0] mask_q;

  always_ff @(posedge sr_clk or posedge ar) begin
    if (ar)          mask_q <= '0;
    else if (accept) mask_q <= bus.chan_mask;
  end

  assign mask_d = accept ? bus.chan_mask : mask_q;
`else
  assign mask_d = '0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rst_cnt_d = '0;
    hold_d    = accept ? bus.data_in : hold_q;
    fe_d      = fe_q;
    pend_d    = pend_q;
    latch_d   = word_end;
    ser_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (led_reset_req) state_d = RST;
        else if (accept)   state_d = ONE;
      end
      ONE:  if (word_end) state_d = DATA;
      DATA: if (word_end) state_d = ZERO;
      ZERO: begin
        if (word_end) begin
          if (fe_q || pend_q || led_reset_req) state_d = RST;
          else if (accept)                     state_d = ONE;
          else                                 state_d = IDLE;
        end
      end
      RST: begin
        if (rst_last) state_d = accept ? ONE : IDLE;
        else          rst_cnt_d = rst_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) bit_cnt_d = word_end ? '0 : bit_cnt_q + 1'b1;

    if (led_reset_req && (state_q inside {ONE, DATA, ZERO})) pend_d = 1'b1;
    if ((state_d == RST) && (state_q != RST)) begin
      pend_d = 1'b0;
      fe_d   = 1'b0;
    end
    if (accept) fe_d = bus.frame_end;

    // ser_out is decoded from the next state so it lines up with the registered state
    unique case (state_d)
      ONE:     ser_d = ~mask_d[bit_cnt_d];
      DATA:    ser_d = hold_d[bit_cnt_d] & ~mask_d[bit_cnt_d];
      default: ser_d = 1'b0;
    endcase
  end

  always_ff @(posedge sr_clk or posedge ar) begin
    if (ar) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rst_cnt_q <= '0;
      hold_q    <= '0;
      fe_q      <= 1'b0;
      pend_q    <= 1'b0;
      ser_q     <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      hold_q    <= hold_d;
      fe_q      <= fe_d;
      pend_q    <= pend_d;
      ser_q     <= ser_d;
      latch_q   <= latch_d;
    end
  end
endmodule

// File: tb/tb_sr_ctrl_multi.sv
// Bench for sr_ctrl_multi: directed scenarios then random traffic against a slot-stream reference model.
// Define SR_CHAN_MASK_EN for both RTL and bench to exercise chan_mask.
module tb_sr_ctrl_multi;
  localparam int unsigned CH = 8;
  localparam int unsigned RS = 4;

  typedef struct packed {
    logic ser;
    logic wend;
    logic zend;
    logic fe;
    logic rst;
    logic rlast;
  } slot_t;

  logic          sr_clk = 1'b0;
  logic          ar = 1'b1;
  logic          led_reset_req = 1'b0;
  logic          ser_out, sr_latch, busy;
  logic [CH-1:0] mask_in = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  slot_t q[$];
  logic  pend_m  = 1'b0;
  logic  latch_m = 1'b0;

  sr_ctrl_multi_if #(.CHANNELS(CH)) bus ();

`ifdef SR_CHAN_MASK_EN
  assign bus.chan_mask = mask_in;
`endif

  sr_ctrl_multi #(.CHANNELS(CH), .RESET_SLOTS(RS)) dut (
    .sr_clk        (sr_clk),
    .ar            (ar),
    .bus           (bus),
    .led_reset_req (led_reset_req),
    .ser_out       (ser_out),
    .sr_latch      (sr_latch),
    .busy          (busy)
  );

  always #5 sr_clk = ~sr_clk;

  function automatic slot_t mk(logic ser, logic wend, logic zend, logic fe, logic rst, logic rlast);
    slot_t s;
    s.ser = ser; s.wend = wend; s.zend = zend; s.fe = fe; s.rst = rst; s.rlast = rlast;
    return s;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_triple(input logic [CH-1:0] d, input logic fe, input logic [CH-1:0] m);
    for (int i = 0; i < int'(CH); i++) q.push_back(mk(~m[i], i == CH - 1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < int'(CH); i++) q.push_back(mk(d[i] & ~m[i], i == CH - 1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < int'(CH); i++) q.push_back(mk(1'b0, i == CH - 1, i == CH - 1, fe, 1'b0, 1'b0));
  endtask

  task automatic push_rst();
    for (int i = 0; i < int'(RS * CH); i++)
      q.push_back(mk(1'b0, (i % CH) == CH - 1, 1'b0, 1'b0, 1'b1, i == RS * CH - 1));
    pend_m = 1'b0;
  endtask

  task automatic model_clear();
    q.delete();
    pend_m  = 1'b0;
    latch_m = 1'b0;
  endtask

  // One clock cycle: drive, check at negedge against the model, advance the model, move past posedge.
  task automatic step(input logic v, input logic [CH-1:0] d, input logic fe, input logic req, output logic acc);
    logic  exp_rdy, have;
    slot_t cur;
    bus.data_valid = v;
    bus.data_in    = d;
    bus.frame_end  = fe;
    led_reset_req  = req;
    @(negedge sr_clk);
    have    = (q.size() != 0);
    exp_rdy = !pend_m && !req && (!have || (q[0].zend && !q[0].fe) || q[0].rlast);
    chk("busy", busy, have);
    chk("ser_out", ser_out, have ? q[0].ser : 1'b0);
    chk("sr_latch", sr_latch, latch_m);
    chk("data_ready", bus.data_ready, exp_rdy);
    acc = v && exp_rdy;
    cur = '0;
    if (have) cur = q.pop_front();
    latch_m = have && cur.wend;
    if (!have) begin
      if (req)      push_rst();
      else if (acc) push_triple(d, fe, mask_in);
    end else begin
      if (req && !cur.rst && !pend_m) pend_m = 1'b1;
      if (cur.zend && (cur.fe || pend_m)) push_rst();
      else if (acc)                       push_triple(d, fe, mask_in);
    end
    @(posedge sr_clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, a);
  endtask

  task automatic send(input logic [CH-1:0] d, input logic fe);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 200 && !a; i++) step(1'b1, d, fe, 1'b0, a);
    if (!a) begin
      miscompares++;
      $display("FAIL send_timeout: word %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic async_reset_check(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ser_out"}, ser_out, 1'b0);
    chk({tag, "_sr_latch"}, sr_latch, 1'b0);
    chk({tag, "_data_ready"}, bus.data_ready, 1'b0);
  endtask

  initial begin
    logic a;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    bus.frame_end  = 1'b0;

    repeat (2) @(posedge sr_clk);
    #1;
    async_reset_check("reset");
    ar = 1'b0;
    model_clear();

    // single word, no frame end
    send(8'hA5, 1'b0);
    idle(30);

    // valid held across two words: gapless ONE after ZERO
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    idle(30);

    // frame end -> LED reset after ZERO word
    send(8'h3C, 1'b1);
    idle(70);

    // reset request while in DATA is deferred to the end of the triple
    send(8'h5A, 1'b0);
    idle(10);
    step(1'b0, '0, 1'b0, 1'b1, a);
    idle(70);

    // request and valid together in IDLE: reset wins, word refused
    step(1'b1, 8'h77, 1'b0, 1'b1, a);
    idle(40);

`ifdef SR_CHAN_MASK_EN
    mask_in = 8'h0F;
    send(8'hFF, 1'b0);
    mask_in = '0;
    idle(30);
`endif

    // async reset in the middle of a DATA word
    send(8'hC3, 1'b0);
    idle(12);
    #2 ar = 1'b1;
    #1 async_reset_check("mid_ar");
    @(posedge sr_clk);
    #1 async_reset_check("held_ar");
    ar = 1'b0;
    model_clear();
    idle(3);

    for (int i = 0; i < 2500; i++) begin
`ifdef SR_CHAN_MASK_EN
      mask_in = CH'($urandom);
`endif
      step($urandom_range(0, 9) < 7, CH'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 59) == 0, a);
    end
    idle(80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
